// File: rtl/serial_compare_lsb.sv
// Bit-serial LSB-first magnitude comparator; one bit pair per clock, result WIDTH cycles after accept.
// Optional two's-complement mode selected by defining SIGNED_CMP_EN.
module serial_compare_lsb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [CW-1:0]    cnt;
  logic             gt_acc;
  logic             lt_acc;
  logic             gt_nxt;
  logic             lt_nxt;
  logic             last_bit;
  logic             accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last_bit  = (cnt == CW'(WIDTH - 1));

  // Later (higher) bits overwrite the accumulators, so the MSB-most difference wins.
  always_comb begin
    gt_nxt = gt_acc;
    lt_nxt = lt_acc;
    if (a_sr[0] != b_sr[0]) begin
`ifdef SIGNED_CMP_EN
      if (last_bit) begin
        gt_nxt = b_sr[0];
        lt_nxt = a_sr[0];
      end else begin
        gt_nxt = a_sr[0];
        lt_nxt = b_sr[0];
      end
`else
      gt_nxt = a_sr[0];
      lt_nxt = b_sr[0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)          state_nxt = SHIFT;
      SHIFT:   if (last_bit)          state_nxt = DONE;
      DONE:    if (out_ready)         state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      cnt    <= '0;
      gt_acc <= 1'b0;
      lt_acc <= 1'b0;
      gt     <= 1'b0;
      lt     <= 1'b0;
      eq     <= 1'b0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      cnt    <= '0;
      gt_acc <= 1'b0;
      lt_acc <= 1'b0;
    end else if (state == SHIFT) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      gt_acc <= gt_nxt;
      lt_acc <= lt_nxt;
      if (last_bit) begin
        // Results are retained after the drain until the next compare finishes.
        gt <= gt_nxt;
        lt <= lt_nxt;
        eq <= ~(gt_nxt | lt_nxt);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_compare_lsb.sv
// Bench for serial_compare_lsb: directed vectors, a timing/value model and a per-cycle compare.
module tb_serial_compare_lsb;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             in_ready;
  logic             out_valid;
  logic             gt;
  logic             lt;
  logic             eq;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  serial_compare_lsb #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gt        (gt),
    .lt        (lt),
    .eq        (eq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference result {gt,lt,eq} straight from integer comparison.
  function automatic logic [2:0] ref_cmp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef SIGNED_CMP_EN
    if ($signed(x) > $signed(y)) return 3'b100;
    if ($signed(x) < $signed(y)) return 3'b010;
`else
    if (x > y) return 3'b100;
    if (x < y) return 3'b010;
`endif
    return 3'b001;
  endfunction

  // Protocol model: 0 idle, 1 computing (m_left cycles to go), 2 result pending.
  int       m_phase = 0;
  int       m_left  = 0;
  logic [2:0] m_res = 3'b000;
  logic [2:0] p_res = 3'b000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_left  <= 0;
      m_res   <= 3'b000;
      p_res   <= 3'b000;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_phase <= 1;
          m_left  <= WIDTH;
          p_res   <= ref_cmp(a, b);
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_phase <= 2;
            m_res   <= p_res;
          end
        end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 32'(in_ready), 32'(m_phase == 0));
      chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
      chk("result", 32'({gt, lt, eq}), 32'(m_res));
      if (out_valid) chk("onehot", 32'($onehot({gt, lt, eq})), 32'd1);
    end
  end

  task automatic wait_accept(input string nm);
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 40) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic run_cmp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic [2:0] exp, input int hold, input string nm);
    int lat;
    @(posedge clk); #1;
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    wait_accept(nm);
    #1;
    in_valid = 1'b0;
    a = ~x; b = ~y;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(WIDTH));
    chk(nm, 32'({gt, lt, eq}), 32'(exp));
    chk({nm, "_model"}, 32'(m_res), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      in_valid = (i == 2);
      @(posedge clk); #1;
      chk({nm, "_hold"}, 32'({out_valid, in_ready, gt, lt, eq}), 32'({2'b10, exp}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_drain"}, 32'({out_valid, in_ready}), 32'b01);
    chk({nm, "_retain"}, 32'({gt, lt, eq}), 32'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, n_pass=%0d n_chk=%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int last_acc;
    #12;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", 32'({gt, lt, eq}), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    run_cmp(8'h5A, 8'h5A, 3'b001, 0, "eq_5a");
    run_cmp(8'h01, 8'h00, 3'b100, 0, "gt_01_00");
`ifdef SIGNED_CMP_EN
    run_cmp(8'h80, 8'h7F, 3'b010, 0, "msb_80_7f");
    run_cmp(8'h81, 8'h40, 3'b010, 0, "override_81_40");
    run_cmp(8'h00, 8'hFF, 3'b100, 0, "zero_vs_ff");
`else
    run_cmp(8'h80, 8'h7F, 3'b100, 0, "msb_80_7f");
    run_cmp(8'h81, 8'h40, 3'b100, 0, "override_81_40");
    run_cmp(8'h00, 8'hFF, 3'b010, 0, "zero_vs_ff");
`endif
    run_cmp(8'hFF, 8'hFF, 3'b001, 0, "eq_ff");
    run_cmp(8'h01, 8'h00, 3'b100, 5, "backpressure");

    // Abort a compare three bit-steps in; prior result (gt) must be wiped.
    @(posedge clk); #1;
    a = 8'h33; b = 8'h44; in_valid = 1'b1;
    wait_accept("abort");
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_result", 32'({gt, lt, eq}), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    run_cmp(8'h10, 8'h20, 3'b010, 0, "after_abort");

    // Back-to-back stream with in_valid held and out_ready held.
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    last_acc = 0;
    for (int i = 0; i < 1000; i++) begin
      wait_accept("stream");
      if (i > 0) chk("stream_interval", 32'(cyc - last_acc), 32'(WIDTH + 2));
      last_acc = cyc;
      #1;
      a = WIDTH'($urandom);
      b = (i % 37 == 0) ? a : WIDTH'($urandom);
    end
    in_valid = 1'b0;
    repeat (WIDTH + 4) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
